// File: rtl/restador_pkg.sv
// Shared constants for the restador push-button down-counter.
package restador_pkg;

  // Idle (released) level of an active-low push-button.
  localparam logic BTN_IDLE = 1'b1;

endpackage

// File: rtl/btn_press_detect.sv
// Synchronizes, debounces and edge-detects an active-low push-button.
// Emits a one-cycle press pulse on each falling edge of the debounced level.
module btn_press_detect
  import restador_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  logic deb;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= BTN_IDLE;
      sync2_q <= BTN_IDLE;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      prev_q  <= deb;
    end
  end

  generate
    if (DB_CYCLES == 0) begin : g_no_db
      assign deb = sync2_q;
    end else begin : g_db
      localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic          deb_q;

      // Level flips only after DB_CYCLES consecutive cycles of disagreement.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else if (sync2_q != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            deb_q <= sync2_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  // Reset clears both deb and prev_q, so a reset never manufactures a press.
  assign press = prev_q & ~deb;

endmodule

// File: rtl/restador.sv
// N-bit down-counter: loads data_in on reset, decrements once per debounced
// btn_sub press, wrapping modulo 2^N.
module restador #(
  parameter int unsigned N         = 4,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         btn_rst,
  input  logic         btn_sub,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out
);

  logic         press;
  logic [N-1:0] count_q;

  btn_press_detect #(
    .DB_CYCLES(DB_CYCLES)
  ) u_press (
    .clk  (clk),
    .rst_n(btn_rst),
    .btn_n(btn_sub),
    .press(press)
  );

  // Reset load wins over a press arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!btn_rst) begin
      count_q <= data_in;
    end else if (press) begin
      count_q <= count_q - N'(1);
    end
  end

  assign data_out = count_q;

endmodule

// File: tb/tb_restador.sv
// Directed self-checking bench for restador at N=2, 4 and 6 with DB_CYCLES=4.
module tb_restador;

  logic       clk;
  logic       btn_rst;
  logic       btn_sub;
  logic [1:0] data_in2;
  logic [3:0] data_in4;
  logic [5:0] data_in6;
  logic [1:0] data_out2;
  logic [3:0] data_out4;
  logic [5:0] data_out6;

  int checks;
  int failures;

  restador #(.N(2), .DB_CYCLES(4)) u_dut2 (
    .clk(clk), .btn_rst(btn_rst), .btn_sub(btn_sub), .data_in(data_in2), .data_out(data_out2)
  );
  restador #(.N(4), .DB_CYCLES(4)) u_dut4 (
    .clk(clk), .btn_rst(btn_rst), .btn_sub(btn_sub), .data_in(data_in4), .data_out(data_out4)
  );
  restador #(.N(6), .DB_CYCLES(4)) u_dut6 (
    .clk(clk), .btn_rst(btn_rst), .btn_sub(btn_sub), .data_in(data_in6), .data_out(data_out6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_rst = 1'b0;
    tick();
    btn_rst = 1'b1;
    repeat (8) tick();
  endtask

  task automatic press_once();
    btn_sub = 1'b0;
    repeat (10) tick();
    btn_sub = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    data_in2 = 2'd3;
    data_in4 = 4'd13;
    data_in6 = 6'd47;
    do_reset();
    checks++;
    if (data_out2 !== 2'd3) begin
      failures++; $display("FAIL reset_n2 got=%0d want=3", data_out2);
    end
    checks++;
    if (data_out4 !== 4'd13) begin
      failures++; $display("FAIL reset_n4 got=%0d want=13", data_out4);
    end
    checks++;
    if (data_out6 !== 6'd47) begin
      failures++; $display("FAIL reset_n6 got=%0d want=47", data_out6);
    end
  endtask

  task automatic test_press();
    press_once();
    checks++;
    if (data_out2 !== 2'd2) begin
      failures++; $display("FAIL press1_n2 got=%0d want=2", data_out2);
    end
    checks++;
    if (data_out4 !== 4'd12) begin
      failures++; $display("FAIL press1_n4 got=%0d want=12", data_out4);
    end
    checks++;
    if (data_out6 !== 6'd46) begin
      failures++; $display("FAIL press1_n6 got=%0d want=46", data_out6);
    end
    press_once();
    checks++;
    if (data_out2 !== 2'd1) begin
      failures++; $display("FAIL press2_n2 got=%0d want=1", data_out2);
    end
    checks++;
    if (data_out4 !== 4'd11) begin
      failures++; $display("FAIL press2_n4 got=%0d want=11", data_out4);
    end
    checks++;
    if (data_out6 !== 6'd45) begin
      failures++; $display("FAIL press2_n6 got=%0d want=45", data_out6);
    end
    do_reset();
    checks++;
    if (data_out2 !== 2'd3) begin
      failures++; $display("FAIL rereset_n2 got=%0d want=3", data_out2);
    end
    checks++;
    if (data_out4 !== 4'd13) begin
      failures++; $display("FAIL rereset_n4 got=%0d want=13", data_out4);
    end
    checks++;
    if (data_out6 !== 6'd47) begin
      failures++; $display("FAIL rereset_n6 got=%0d want=47", data_out6);
    end
  endtask

  task automatic test_wrap();
    data_in2 = 2'd0;
    data_in4 = 4'd0;
    do_reset();
    press_once();
    checks++;
    if (data_out4 !== 4'd15) begin
      failures++; $display("FAIL wrap_n4 got=%0d want=15", data_out4);
    end
    checks++;
    if (data_out2 !== 2'd3) begin
      failures++; $display("FAIL wrap_n2 got=%0d want=3", data_out2);
    end
  endtask

  task automatic test_glitch_and_latency();
    data_in4 = 4'd8;
    do_reset();
    btn_sub = 1'b0;
    repeat (2) tick();
    btn_sub = 1'b1;
    repeat (8) tick();
    checks++;
    if (data_out4 !== 4'd8) begin
      failures++; $display("FAIL glitch got=%0d want=8", data_out4);
    end
    // Stable press: output must move on the 7th edge, not the 6th.
    btn_sub = 1'b0;
    repeat (6) tick();
    checks++;
    if (data_out4 !== 4'd8) begin
      failures++; $display("FAIL latency_early got=%0d want=8", data_out4);
    end
    tick();
    checks++;
    if (data_out4 !== 4'd7) begin
      failures++; $display("FAIL latency_edge7 got=%0d want=7", data_out4);
    end
    repeat (3) tick();
    checks++;
    if (data_out4 !== 4'd7) begin
      failures++; $display("FAIL hold_no_repeat got=%0d want=7", data_out4);
    end
    btn_sub = 1'b1;
    repeat (10) tick();
    checks++;
    if (data_out4 !== 4'd7) begin
      failures++; $display("FAIL release_no_change got=%0d want=7", data_out4);
    end
  endtask

  task automatic test_data_in_ignored();
    data_in4 = 4'd2;
    repeat (4) tick();
    checks++;
    if (data_out4 !== 4'd7) begin
      failures++; $display("FAIL data_in_ignored got=%0d want=7", data_out4);
    end
  endtask

  task automatic test_hold_across_reset();
    data_in4 = 4'd5;
    btn_sub  = 1'b0;
    btn_rst  = 1'b0;
    tick();
    btn_rst = 1'b1;
    repeat (15) tick();
    checks++;
    if (data_out4 !== 4'd5) begin
      failures++; $display("FAIL held_across_reset got=%0d want=5", data_out4);
    end
    btn_sub = 1'b1;
    repeat (10) tick();
    press_once();
    checks++;
    if (data_out4 !== 4'd4) begin
      failures++; $display("FAIL repress_after_reset got=%0d want=4", data_out4);
    end
  endtask

  task automatic test_reset_priority();
    data_in4 = 4'd9;
    do_reset();
    // Reset lands on the edge where the debounced level would fall.
    btn_sub = 1'b0;
    repeat (5) tick();
    btn_rst = 1'b0;
    tick();
    btn_rst = 1'b1;
    repeat (15) tick();
    checks++;
    if (data_out4 !== 4'd9) begin
      failures++; $display("FAIL rst_at_debounce got=%0d want=9", data_out4);
    end
    btn_sub = 1'b1;
    repeat (10) tick();
    // Reset lands on the edge where the press pulse would decrement.
    btn_sub = 1'b0;
    repeat (6) tick();
    btn_rst = 1'b0;
    tick();
    btn_rst = 1'b1;
    checks++;
    if (data_out4 !== 4'd9) begin
      failures++; $display("FAIL rst_vs_press got=%0d want=9", data_out4);
    end
    repeat (15) tick();
    btn_sub = 1'b1;
    repeat (10) tick();
    checks++;
    if (data_out4 !== 4'd9) begin
      failures++; $display("FAIL no_late_press got=%0d want=9", data_out4);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    btn_rst  = 1'b1;
    btn_sub  = 1'b1;
    data_in2 = '0;
    data_in4 = '0;
    data_in6 = '0;
    repeat (2) tick();
    test_reset();
    test_press();
    test_wrap();
    test_glitch_and_latency();
    test_data_in_ignored();
    test_hold_across_reset();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
